doc_uart_sender: RTL
====================

// Module: doc_uart_sender
// PURPOSE
//  Downstream consumer of the document RAM: on a send pulse, walks all 16x32 character cells,
//  serialises each as 8N1 UART on RsTx, and appends CR LF after every row. It drives the
//  document's read port (read_en/read_addr) and sits between the text editor/document and the board TX pin.
// PARAMETERS
//  CLK_HZ    100_000_000  system clock frequency
//  BAUD      115200       line rate; BAUD_DIV = CLK_HZ/BAUD (868 at defaults), integer-truncated
//  ROWS      16           document rows (row index = read_addr[8:5])
//  COLS      32           document columns (col index = read_addr[4:0])
//  ADDR_W    10           read_addr width; bit 9 always 0
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous, active-high reset
//  send       in   1       start request, already one-pulsed upstream
//  read_data  in   8       document character at read_addr, asynchronous read (valid same cycle)
//  read_en    out  1       high for exactly one cycle per character fetch; editor muxes read_addr in
//  read_addr  out  ADDR_W  {1'b0, row[3:0], col[4:0]}
//  busy       out  1       high from the cycle after accepted send until done
//  done       out  1       one-cycle pulse after final LF stop bit
//  RsTx       out  1       UART serial out, idle high
// BEHAVIOUR
//  - Reset (or rst mid-transfer): next edge gives RsTx=1, read_en=0, read_addr=0, busy=0, done=0,
//    FSM=IDLE, row/col=0, bit and baud counters=0; any partial frame is abandoned.
//  - FSM: IDLE -> FETCH -> TX_CHAR -> (col<COLS-1 ? FETCH, col+1 : TX_CR) -> TX_LF ->
//    (row<ROWS-1 ? FETCH, row+1, col=0 : DONE) -> IDLE. DONE lasts one cycle: done=1, busy=0.
//  - IDLE: send=1 accepted, busy=1 next cycle. send while busy is ignored (not queued).
//  - FETCH: read_en=1 for one cycle; read_data captured on that edge into char_q.
//  - Char mapping: 0x00 -> 0x20 (space); 0x80..0xFF -> 0x3F ('?'); all else sent unchanged.
//  - TX_CR sends 0x0D, TX_LF sends 0x0A; no trimming of trailing spaces.
//  - Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly BAUD_DIV cycles.
//    Next frame's start bit begins the cycle after the stop bit ends + FETCH overhead (<=2 cycles idle-high gap).
//  - Total transfer: ROWS*(COLS+2) = 544 bytes; busy length = 5440*BAUD_DIV + fetch overhead.
//  - Baud counter counts 0..BAUD_DIV-1 then wraps, advancing bit index 0..9; index 9 end = frame done.
//  - send asserted in the same cycle as done: ignored (accepted only in IDLE).
//  - read_en never asserted outside FETCH; read_addr holds last value otherwise.
// STRUCTURE
//  - Shared header doc_defs.vh: DOC_ROWS=16, DOC_COLS=32, CHAR_SPACE=8'h20, CHAR_CR=8'h0D,
//    CHAR_LF=8'h0A, CHAR_BAD=8'h3F, FSM state encodings.
//  - One sub-module: uart_tx_byte (clk, rst, start, data[7:0], busy, tx) with BAUD_DIV parameter;
//    top-level FSM handles addressing, mapping, CR/LF sequencing.
// TESTING  (bench overrides CLK_HZ=1000, BAUD=100 -> BAUD_DIV=10)
//  - Reset: rst high 2 cycles -> RsTx=1, busy=0, read_en=0, done=0; no activity for 1000 cycles without send.
//  - Single byte timing: doc[0]=0x41 ('A'), send pulse -> RsTx low 10 cycles, then 1,0,0,0,0,0,1,0 each
//    10 cycles, stop high 10 cycles; first read_en with read_addr=0.
//  - Full sweep: doc filled with (addr&0x3F)+0x30 -> UART monitor decodes 544 bytes, 32 chars + 0D 0A
//    per row in address order; done pulses once, busy low after.
//  - Mapping: doc[5]=0x00, doc[6]=0x9F -> bytes 6,7 of stream are 0x20, 0x3F.
//  - Re-send while busy: send pulse at byte 10 -> ignored, exactly 544 bytes, one done pulse.
//  - Reset mid-frame: rst during data bit 3 of byte 40 -> RsTx=1 next cycle, busy=0; fresh send
//    restarts from read_addr=0 and yields a correct 544-byte stream.

Source files
------------

// File: rtl/doc_uart_sender_pkg.sv
// -----------------------------------------------------------------------------
// doc_uart_sender_pkg
//   Shared definitions for the document UART sender: document geometry,
//   the fixed characters injected into the stream, the frame length, the
//   top-level FSM state encoding and the character substitution rule.
//
//   Contents:
//     DOC_ROWS / DOC_COLS   document geometry (16 rows x 32 columns)
//     CHAR_SPACE            replacement for NUL cells
//     CHAR_CR / CHAR_LF     end-of-row sequence
//     CHAR_BAD              replacement for non-ASCII (bit 7 set) cells
//     FRAME_BITS            8N1 frame length: start + 8 data + stop
//     state_e               top-level sequencer states
//     map_char()            cell value -> transmitted byte
// -----------------------------------------------------------------------------
package doc_uart_sender_pkg;

    localparam int DOC_ROWS = 16;
    localparam int DOC_COLS = 32;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_BAD   = 8'h3F;

    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_TX_CHAR = 3'd2,
        ST_TX_CR   = 3'd3,
        ST_TX_LF   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Empty cells print as blanks so the terminal keeps its column alignment;
    // anything outside 7-bit ASCII is shown as '?' rather than raw bytes.
    function automatic logic [7:0] map_char(input logic [7:0] c);
        logic [7:0] m;
        m = c;
        if (c == 8'h00) begin
            m = CHAR_SPACE;
        end else if (c[7]) begin
            m = CHAR_BAD;
        end
        return m;
    endfunction

endpackage

// File: rtl/doc_uart_sender_uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
//   Single-byte 8N1 UART transmitter. A start request while idle latches the
//   byte and emits start bit (0), eight data bits LSB first, and a stop bit
//   (1), each held for exactly BAUD_DIV clock cycles. Requests while busy
//   are ignored.
//
//   Ports:
//     clk    in   1   system clock
//     rst    in   1   synchronous active-high reset (line returns high)
//     start  in   1   launch a frame with 'data' (honoured only when idle)
//     data   in   8   byte to send, sampled on the accepting edge
//     busy   out  1   high from the first start-bit cycle to the end of stop
//     tx     out  1   serial line, idle high, registered
// -----------------------------------------------------------------------------
module uart_tx_byte
    import doc_uart_sender_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int              CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(FRAME_BITS - 1);

    logic [CNT_W-1:0] baud_q;
    logic [3:0]       bit_q;     // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]       shift_q;   // remaining data bits, next one in [0]
    logic             busy_q;
    logic             tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else if (!busy_q) begin
            if (start) begin
                busy_q  <= 1'b1;
                tx_q    <= 1'b0;
                shift_q <= data;
                baud_q  <= '0;
                bit_q   <= '0;
            end
        end else if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
                // Stop bit has been held its full period: release the line.
                busy_q <= 1'b0;
                tx_q   <= 1'b1;
                bit_q  <= '0;
            end else begin
                bit_q <= bit_q + 4'd1;
                // Leaving start or a data bit: drive the next data bit, or
                // the stop bit once all eight have gone out.
                if (bit_q < 4'd8) begin
                    tx_q    <= shift_q[0];
                    shift_q <= {1'b0, shift_q[7:1]};
                end else begin
                    tx_q <= 1'b1;
                end
            end
        end else begin
            baud_q <= baud_q + CNT_W'(1);
        end
    end

    assign busy = busy_q;
    assign tx   = tx_q;

endmodule

// File: rtl/doc_uart_sender.sv
// -----------------------------------------------------------------------------
// doc_uart_sender
//   Dumps the whole document RAM over UART. On an accepted send pulse it
//   walks every cell in row-major order, fetching each character through the
//   document's asynchronous read port, substitutes unprintable cells, and
//   transmits it as 8N1. Every row is terminated with CR LF. A one-cycle
//   done pulse follows the final LF stop bit.
//
//   Ports:
//     clk        in   1       system clock
//     rst        in   1       synchronous active-high reset, aborts a transfer
//     send       in   1       start request (single-cycle pulse), IDLE only
//     read_data  in   8       document byte at read_addr, same-cycle valid
//     read_en    out  1       one-cycle fetch strobe per character
//     read_addr  out  ADDR_W  {0, row, col}; holds between fetches
//     busy       out  1       transfer in progress
//     done       out  1       one-cycle pulse at end of transfer
//     RsTx       out  1       UART serial out, idle high
// -----------------------------------------------------------------------------
module doc_uart_sender
    import doc_uart_sender_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int ROWS   = DOC_ROWS,
    parameter int COLS   = DOC_COLS,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [7:0]        read_data,
    output logic              read_en,
    output logic [ADDR_W-1:0] read_addr,
    output logic              busy,
    output logic              done,
    output logic              RsTx
);

    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
        return ADDR_W'({r, c});
    endfunction

    state_e              state_q;
    logic [ROW_W-1:0]    row_q;
    logic [COL_W-1:0]    col_q;
    logic [7:0]          char_q;
    logic                launched_q;   // current state's frame has been started
    logic                read_en_q;
    logic [ADDR_W-1:0]   read_addr_q;
    logic                busy_q;
    logic                done_q;

    logic                tx_start;
    logic [7:0]          tx_data;
    logic                tx_busy;
    logic                tx_line;
    logic [7:0]          fetch_char;
    logic                frame_done;

    assign fetch_char = map_char(read_data);
    assign frame_done = launched_q & ~tx_busy;

    // The transmitter is started straight out of FETCH with the mapped read
    // data, so the line idles at most two cycles between back-to-back frames
    // (one cycle to notice the stop bit ended, one for the fetch).
    always_comb begin
        tx_start = 1'b0;
        tx_data  = char_q;
        case (state_q)
            ST_FETCH: begin
                tx_start = 1'b1;
                tx_data  = fetch_char;
            end
            ST_TX_CR: begin
                tx_start = ~launched_q;
                tx_data  = CHAR_CR;
            end
            ST_TX_LF: begin
                tx_start = ~launched_q;
                tx_data  = CHAR_LF;
            end
            default: begin
                tx_start = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            char_q      <= '0;
            launched_q  <= 1'b0;
            read_en_q   <= 1'b0;
            read_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Strobes default low; the case below re-raises them as needed.
            read_en_q <= 1'b0;
            done_q    <= 1'b0;
            if (tx_start) begin
                launched_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (send) begin
                        state_q     <= ST_FETCH;
                        busy_q      <= 1'b1;
                        row_q       <= '0;
                        col_q       <= '0;
                        read_en_q   <= 1'b1;
                        read_addr_q <= '0;
                    end
                end

                ST_FETCH: begin
                    char_q  <= fetch_char;
                    state_q <= ST_TX_CHAR;
                end

                ST_TX_CHAR: begin
                    if (frame_done) begin
                        if (col_q != COL_LAST) begin
                            col_q       <= col_q + COL_W'(1);
                            state_q     <= ST_FETCH;
                            read_en_q   <= 1'b1;
                            read_addr_q <= addr_of(row_q, col_q + COL_W'(1));
                        end else begin
                            state_q    <= ST_TX_CR;
                            launched_q <= 1'b0;
                        end
                    end
                end

                ST_TX_CR: begin
                    if (frame_done) begin
                        state_q    <= ST_TX_LF;
                        launched_q <= 1'b0;
                    end
                end

                ST_TX_LF: begin
                    if (frame_done) begin
                        if (row_q != ROW_LAST) begin
                            row_q       <= row_q + ROW_W'(1);
                            col_q       <= '0;
                            state_q     <= ST_FETCH;
                            read_en_q   <= 1'b1;
                            read_addr_q <= addr_of(row_q + ROW_W'(1), '0);
                        end else begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (tx_start),
        .data  (tx_data),
        .busy  (tx_busy),
        .tx    (tx_line)
    );

    assign read_en   = read_en_q;
    assign read_addr = read_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign RsTx      = tx_line;

endmodule
